acs_butterfly_pipe: RTL
=======================

Name: acs_butterfly_pipe

Overview:
- Parametrised, pipelined add-compare-select butterfly for the rate-1/2 soft-decision Viterbi decoder.
- Takes two soft received symbols, two old-state path metrics and two old-state decision histories. Produces two new-state path metrics and histories, with survivor decision bits appended.
- Adds over the fixed-width stage: valid handshake, unsigned offset branch metrics, tie rule, overflow-free metric normalization, configurable history depth.
- Sits between the symbol front end and the traceback/output logic; one instance per butterfly in the trellis.

Parameters:
- SW, 8, soft-symbol width (signed two's complement).
- MW, 12, path-metric width (unsigned); elaboration error if MW < SW+4.
- HIST_LEN, 8, decision-history bits carried per state (>=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- in_valid  in  1  qualifies all inputs this cycle.
- r0  in  SW  signed soft symbol, first code bit (positive = bit 0).
- r1  in  SW  signed soft symbol, second code bit.
- pm_a  in  MW  path metric, old state A.
- pm_b  in  MW  path metric, old state B.
- hist_a  in  HIST_LEN  decision history, state A.
- hist_b  in  HIST_LEN  decision history, state B.
- out_valid  out  1  outputs updated this cycle.
- pm_p  out  MW  new metric, state P.
- pm_q  out  MW  new metric, state Q.
- hist_p  out  HIST_LEN  new history, state P.
- hist_q  out  HIST_LEN  new history, state Q.
- dec_p  out  1  decision for P (0 = from A, 1 = from B).
- dec_q  out  1  decision for Q (0 = from A, 1 = from B).
- norm  out  1  normalization applied to this output pair.

Behaviour:
- Reset: RST sampled high at a rising edge clears all pipeline registers and all outputs to 0 (out_valid=0, pm_*=0, hist_*=0, dec_*=0, norm=0).
- Reset mid-operation discards in-flight data; in_valid in the reset cycle is ignored.
- Stage 1 (registered when in_valid=1):
  - K = 2^SW.
  - bm00 = K - r0 - r1; bm11 = K + r0 + r1.
  - Both are unsigned, SW+2 bits, range 0..2^(SW+1).
  - Also registers pm_a, pm_b, hist_a, hist_b and a stage-1 valid bit.
- Stage 2 (registered when the stage-1 valid bit is set), all sums on MW+1 bits:
  - P candidates: cA = pm_a+bm00, cB = pm_b+bm11.
  - Q candidates: cA = pm_a+bm11, cB = pm_b+bm00.
  - Winner is the smaller candidate; tie selects A (dec=0).
  - If both winners >= 2^(MW-1): subtract 2^(MW-1) from both and set norm=1; else norm=0.
  - The result is truncated to MW bits; by the MW >= SW+4 constraint, truncation never loses bits.
  - hist_p = {selected_hist[HIST_LEN-2:0], dec_p}; likewise for hist_q.
- Latency: exactly 2 cycles from in_valid to out_valid.
  - Throughput: one butterfly per cycle.
  - No back-pressure.
- out_valid is a 1-cycle pulse per accepted input. Back-to-back inputs give back-to-back pulses.
- Outputs hold their last values while out_valid=0.
- in_valid low: stage registers hold and no spurious out_valid.

Optional Feature:
- Macro SYMBOL_ERASE_EN, for punctured codes.
- Defined:
  - Adds inputs erase0 and erase1 (1 bit each, qualified by in_valid).
  - An erased symbol is replaced by 0 before the branch-metric sum.
  - Erasures travel with stage 1; no latency change.
- Undefined:
  - Ports are absent.
  - Symbols are always used as received.

Decomposition:
- Package viterbi_pkg holds:
  - default SW/MW/HIST_LEN constants;
  - decision-encoding constants DEC_FROM_A=0, DEC_FROM_B=1;
  - a branch-metric offset function returning K=2^SW.
- Sub-module branch_metric_unit: stage-1 registered bm00/bm11 computation, including the erasure masking.
- Top performs ACS, normalization and history update.

Test Plan (SW=8, MW=12, HIST_LEN=8):
- Nominal ACS: r0=10, r1=20, pm_a=100, pm_b=50, hist_a=0x00, hist_b=0xFF.
  - 2 cycles later: pm_p=326, dec_p=0, hist_p=0x00.
  - pm_q=276, dec_q=1, hist_q=0xFF.
  - norm=0.
- Tie: r0=r1=0, pm_a=pm_b=0 -> pm_p=pm_q=256, dec_p=dec_q=0.
- Normalization: r0=r1=0, pm_a=pm_b=2000 -> pm_p=pm_q=208, norm=1.
  - Repeat with pm_b=1000 -> pm_p=pm_q=1256, norm=0.
- Extremes: r0=r1=-128, pm_a=pm_b=4000 -> dec_p=1, dec_q=0, pm_p=pm_q=1952, norm=1.
- Handshake/reset:
  - Three back-to-back in_valid pulses, then a gap -> exactly three out_valid pulses at cycles +2..+4, with outputs held afterward.
  - RST asserted 1 cycle after an in_valid -> no out_valid and all outputs 0.
- With SYMBOL_ERASE_EN: r0=100, erase0=1, r1=20, pm_a=pm_b=0 -> pm_p=236, pm_q=236, dec_p=0, dec_q=1.

Source files
------------

// File: rtl/acs_butterfly_pipe_pkg.sv
// Shared constants and helpers for the Viterbi ACS butterfly slice.
// Provides the default widths, the survivor-decision encoding and the
// branch-metric offset K = 2^SW. The offset keeps branch metrics unsigned.
package viterbi_pkg;

  localparam int SW_DEF       = 8;
  localparam int MW_DEF       = 12;
  localparam int HIST_LEN_DEF = 8;

  localparam logic DEC_FROM_A = 1'b0;
  localparam logic DEC_FROM_B = 1'b1;

  // Offset added to both branch metrics so they never go negative.
  function automatic int unsigned bm_offset(input int unsigned sw);
    return 32'd1 << sw;
  endfunction

endpackage

// File: rtl/acs_butterfly_pipe_if.sv
// Butterfly data bus: input symbols/metrics/histories and output metrics,
// histories and decisions.
//   master : drives in_valid, r0, r1, pm_a, pm_b, hist_a, hist_b
//            (+ erase0/erase1 when SYMBOL_ERASE_EN is defined).
//   slave  : drives out_valid, pm_p, pm_q, hist_p, hist_q, dec_p, dec_q, norm.
// Optional macro: SYMBOL_ERASE_EN adds the per-symbol erasure flags.
interface acs_butterfly_pipe_if
  import viterbi_pkg::*;
#(
  parameter int SW       = SW_DEF,
  parameter int MW       = MW_DEF,
  parameter int HIST_LEN = HIST_LEN_DEF
);

  logic                in_valid;
  logic signed [SW-1:0] r0;
  logic signed [SW-1:0] r1;
  logic [MW-1:0]       pm_a;
  logic [MW-1:0]       pm_b;
  logic [HIST_LEN-1:0] hist_a;
  logic [HIST_LEN-1:0] hist_b;
`ifdef SYMBOL_ERASE_EN
  logic                erase0;
  logic                erase1;
`endif

  logic                out_valid;
  logic [MW-1:0]       pm_p;
  logic [MW-1:0]       pm_q;
  logic [HIST_LEN-1:0] hist_p;
  logic [HIST_LEN-1:0] hist_q;
  logic                dec_p;
  logic                dec_q;
  logic                norm;

  modport master (
    output in_valid, r0, r1, pm_a, pm_b, hist_a, hist_b,
`ifdef SYMBOL_ERASE_EN
    output erase0, erase1,
`endif
    input  out_valid, pm_p, pm_q, hist_p, hist_q, dec_p, dec_q, norm
  );

  modport slave (
    input  in_valid, r0, r1, pm_a, pm_b, hist_a, hist_b,
`ifdef SYMBOL_ERASE_EN
    input  erase0, erase1,
`endif
    output out_valid, pm_p, pm_q, hist_p, hist_q, dec_p, dec_q, norm
  );

endinterface

// File: rtl/acs_butterfly_pipe_branch_metric_unit.sv
// Stage-1 branch-metric unit.
// Computes bm00 = K - r0 - r1 and bm11 = K + r0 + r1 (K = 2^SW) and
// registers them when i_en is high; holds otherwise.
// Ports: CLK, RST (sync, active-high), i_en, i_r0, i_r1,
//        [i_erase0, i_erase1 with SYMBOL_ERASE_EN], o_bm00, o_bm11.
// Optional macro: SYMBOL_ERASE_EN forces an erased symbol to 0.
module branch_metric_unit
  import viterbi_pkg::*;
#(
  parameter int SW = SW_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_en,
  input  logic signed [SW-1:0] i_r0,
  input  logic signed [SW-1:0] i_r1,
`ifdef SYMBOL_ERASE_EN
  input  logic                 i_erase0,
  input  logic                 i_erase1,
`endif
  output logic [SW+1:0]        o_bm00,
  output logic [SW+1:0]        o_bm11
);

  localparam logic [SW+1:0] C_K = (SW+2)'(bm_offset(SW));

  logic [SW+1:0] w_s0;
  logic [SW+1:0] w_s1;
  logic [SW+1:0] w_bm00;
  logic [SW+1:0] w_bm11;
  logic [SW+1:0] r_bm00;
  logic [SW+1:0] r_bm11;

  // Sign-extend to SW+2 bits; modular arithmetic then yields the exact
  // unsigned results in 0..2^(SW+1).
`ifdef SYMBOL_ERASE_EN
  assign w_s0 = i_erase0 ? '0 : {{2{i_r0[SW-1]}}, i_r0};
  assign w_s1 = i_erase1 ? '0 : {{2{i_r1[SW-1]}}, i_r1};
`else
  assign w_s0 = {{2{i_r0[SW-1]}}, i_r0};
  assign w_s1 = {{2{i_r1[SW-1]}}, i_r1};
`endif

  assign w_bm00 = C_K - w_s0 - w_s1;
  assign w_bm11 = C_K + w_s0 + w_s1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bm00 <= '0;
      r_bm11 <= '0;
    end else if (i_en) begin
      r_bm00 <= w_bm00;
      r_bm11 <= w_bm11;
    end
  end

  assign o_bm00 = r_bm00;
  assign o_bm11 = r_bm11;

endmodule

// File: rtl/acs_butterfly_pipe.sv
// Two-stage pipelined add-compare-select butterfly for a rate-1/2
// soft-decision Viterbi decoder.
// Stage 1: branch metrics plus registered old metrics/histories.
// Stage 2: ACS for states P and Q, joint normalization, history update.
// Ports: CLK, RST (sync, active-high), bus (acs_butterfly_pipe_if.slave).
// Optional macro: SYMBOL_ERASE_EN (erasure flags on the bus).
module acs_butterfly_pipe
  import viterbi_pkg::*;
#(
  parameter int SW       = SW_DEF,
  parameter int MW       = MW_DEF,
  parameter int HIST_LEN = HIST_LEN_DEF
) (
  input logic                 CLK,
  input logic                 RST,
  acs_butterfly_pipe_if.slave bus
);

  if (MW < SW + 4) begin : g_bad_mw
    $error("acs_butterfly_pipe: MW must be at least SW+4");
  end
  if (HIST_LEN < 2) begin : g_bad_hist
    $error("acs_butterfly_pipe: HIST_LEN must be at least 2");
  end

  localparam logic [MW:0] C_HALF = (MW+1)'(1) << (MW - 1);

  logic [SW+1:0]       w_bm00;
  logic [SW+1:0]       w_bm11;

  logic                r_s1_valid;
  logic [MW-1:0]       r_pm_a;
  logic [MW-1:0]       r_pm_b;
  // The history MSB shifts out in stage 2, so it is never stored.
  logic [HIST_LEN-2:0] r_hist_a;
  logic [HIST_LEN-2:0] r_hist_b;

  logic [MW:0]         w_bm00_x;
  logic [MW:0]         w_bm11_x;
  logic [MW:0]         w_pa;
  logic [MW:0]         w_pb;
  logic [MW:0]         w_qa;
  logic [MW:0]         w_qb;
  logic                w_dec_p;
  logic                w_dec_q;
  logic [MW:0]         w_win_p;
  logic [MW:0]         w_win_q;
  logic                w_norm;
  logic [MW:0]         w_res_p;
  logic [MW:0]         w_res_q;
  logic [HIST_LEN-1:0] w_hist_p;
  logic [HIST_LEN-1:0] w_hist_q;

  logic                r_out_valid;
  logic [MW-1:0]       r_pm_p;
  logic [MW-1:0]       r_pm_q;
  logic [HIST_LEN-1:0] r_hist_p;
  logic [HIST_LEN-1:0] r_hist_q;
  logic                r_dec_p;
  logic                r_dec_q;
  logic                r_norm;

  branch_metric_unit #(.SW(SW)) u_bmu (
    .CLK      (CLK),
    .RST      (RST),
    .i_en     (bus.in_valid),
    .i_r0     (bus.r0),
    .i_r1     (bus.r1),
`ifdef SYMBOL_ERASE_EN
    .i_erase0 (bus.erase0),
    .i_erase1 (bus.erase1),
`endif
    .o_bm00   (w_bm00),
    .o_bm11   (w_bm11)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_pm_a     <= '0;
      r_pm_b     <= '0;
      r_hist_a   <= '0;
      r_hist_b   <= '0;
    end else begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_pm_a   <= bus.pm_a;
        r_pm_b   <= bus.pm_b;
        r_hist_a <= bus.hist_a[HIST_LEN-2:0];
        r_hist_b <= bus.hist_b[HIST_LEN-2:0];
      end
    end
  end

  assign w_bm00_x = (MW+1)'(w_bm00);
  assign w_bm11_x = (MW+1)'(w_bm11);

  assign w_pa = {1'b0, r_pm_a} + w_bm00_x;
  assign w_pb = {1'b0, r_pm_b} + w_bm11_x;
  assign w_qa = {1'b0, r_pm_a} + w_bm11_x;
  assign w_qb = {1'b0, r_pm_b} + w_bm00_x;

  // Strict compare: a tie keeps the A path.
  assign w_dec_p = (w_pb < w_pa) ? DEC_FROM_B : DEC_FROM_A;
  assign w_dec_q = (w_qb < w_qa) ? DEC_FROM_B : DEC_FROM_A;

  assign w_win_p = (w_dec_p == DEC_FROM_B) ? w_pb : w_pa;
  assign w_win_q = (w_dec_q == DEC_FROM_B) ? w_qb : w_qa;

  // Normalize only when both survivors sit in the upper half, so the
  // relative metric difference is preserved across the pair.
  assign w_norm  = (w_win_p >= C_HALF) && (w_win_q >= C_HALF);
  assign w_res_p = w_norm ? (w_win_p - C_HALF) : w_win_p;
  assign w_res_q = w_norm ? (w_win_q - C_HALF) : w_win_q;

  assign w_hist_p = (w_dec_p == DEC_FROM_B) ? {r_hist_b, w_dec_p} : {r_hist_a, w_dec_p};
  assign w_hist_q = (w_dec_q == DEC_FROM_B) ? {r_hist_b, w_dec_q} : {r_hist_a, w_dec_q};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_valid <= 1'b0;
      r_pm_p      <= '0;
      r_pm_q      <= '0;
      r_hist_p    <= '0;
      r_hist_q    <= '0;
      r_dec_p     <= 1'b0;
      r_dec_q     <= 1'b0;
      r_norm      <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        // MW >= SW+4 guarantees the dropped top bit is always zero here.
        r_pm_p   <= MW'(w_res_p);
        r_pm_q   <= MW'(w_res_q);
        r_hist_p <= w_hist_p;
        r_hist_q <= w_hist_q;
        r_dec_p  <= w_dec_p;
        r_dec_q  <= w_dec_q;
        r_norm   <= w_norm;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.pm_p      = r_pm_p;
  assign bus.pm_q      = r_pm_q;
  assign bus.hist_p    = r_hist_p;
  assign bus.hist_q    = r_hist_q;
  assign bus.dec_p     = r_dec_p;
  assign bus.dec_q     = r_dec_q;
  assign bus.norm      = r_norm;

endmodule
